// File: rtl/regfile_pkg.sv
// Shared register-file types and constants for decode, regfile and writeback.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package regfile_pkg;

  localparam int REG_COUNT = 32;
  localparam int DATA_W    = 32;
  localparam int ADDR_W    = 5;

  typedef logic [ADDR_W-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/regfile.sv
// MIPS register file: 32 x 32, two combinational read ports, one synchronous write port, r0 = 0.
// Latency: reads are combinational; a write is visible on the read ports after the writing edge.
// Backpressure: none; a write is accepted on every rising edge with we high and rst_s high.
module regfile #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst_s,
  input  logic              we,
  input  logic [ADDR_W-1:0] raddr_1,
  input  logic [ADDR_W-1:0] raddr_2,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata_1,
  output logic [DATA_W-1:0] rdata_2
);

  localparam int REGS = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [REGS];
  logic              wr_fire;

  // Register 0 reads as zero regardless of what the storage holds.
  function automatic logic [DATA_W-1:0] rd_mux(input logic [ADDR_W-1:0] addr,
                                               input logic [DATA_W-1:0] stored);
    return (addr == '0) ? '0 : stored;
  endfunction

  // Writes to r0 are dropped here, so r0's storage stays at its reset value.
  assign wr_fire = we && (waddr != '0);

  // Storage: async clear on reset, single write per edge, no read bypass.
  always_ff @(posedge clk or negedge rst_s) begin
    if (!rst_s) begin
      for (int i = 0; i < REGS; i++) begin
        mem_q[i] <= '0;
      end
    end else if (wr_fire) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata_1 = rd_mux(raddr_1, mem_q[raddr_1]);
  assign rdata_2 = rd_mux(raddr_2, mem_q[raddr_2]);

endmodule

// File: tb/tb_regfile.sv
// Self-checking bench for regfile: directed scenarios plus randomized traffic against an array model.
// Latency: checks reads combinationally and writes one edge later.
// Backpressure: none.
module tb_regfile;

  logic        clk;
  logic        rst_s;
  logic        we;
  logic [4:0]  raddr_1;
  logic [4:0]  raddr_2;
  logic [4:0]  waddr;
  logic [31:0] wdata;
  logic [31:0] rdata_1;
  logic [31:0] rdata_2;

  int total;
  int bad;

  // Reference model: plain array of register contents.
  logic [31:0] model [32];

  regfile #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk     (clk),
    .rst_s   (rst_s),
    .we      (we),
    .raddr_1 (raddr_1),
    .raddr_2 (raddr_2),
    .waddr   (waddr),
    .wdata   (wdata),
    .rdata_1 (rdata_1),
    .rdata_2 (rdata_2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] model_read(input logic [4:0] a);
    return (a == 5'd0) ? 32'd0 : model[a];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 32; i++) model[i] = 32'd0;
  endtask

  task automatic test_reset();
    rst_s   = 1'b0;
    we      = 1'b0;
    raddr_1 = 5'd5;
    raddr_2 = 5'd7;
    waddr   = 5'd0;
    wdata   = 32'd0;
    #1;
    total++;
    if (rdata_1 !== 32'd0) begin
      bad++;
      $display("FAIL reset_rd1: got %h want %h", rdata_1, 32'd0);
    end
    total++;
    if (rdata_2 !== 32'd0) begin
      bad++;
      $display("FAIL reset_rd2: got %h want %h", rdata_2, 32'd0);
    end
    we    = 1'b1;
    waddr = 5'd5;
    wdata = 32'd10;
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata_1 !== 32'd0) begin
      bad++;
      $display("FAIL reset_write_ignored: got %h want %h", rdata_1, 32'd0);
    end
    model_clear();
  endtask

  task automatic test_basic();
    rst_s   = 1'b1;
    tick();
    we      = 1'b1;
    waddr   = 5'd5;
    wdata   = 32'd10;
    raddr_1 = 5'd5;
    #1;
    total++;
    if (rdata_1 !== 32'd0) begin
      bad++;
      $display("FAIL basic_before_edge: got %h want %h", rdata_1, 32'd0);
    end
    tick();
    model[5] = 32'd10;
    we = 1'b0;
    #1;
    total++;
    if (rdata_1 !== 32'd10) begin
      bad++;
      $display("FAIL basic_after_edge: got %h want %h", rdata_1, 32'd10);
    end
    raddr_2 = 5'd7;
    #1;
    total++;
    if (rdata_2 !== 32'd0) begin
      bad++;
      $display("FAIL basic_unwritten: got %h want %h", rdata_2, 32'd0);
    end
  endtask

  task automatic test_cross_port();
    we      = 1'b1;
    waddr   = 5'd6;
    wdata   = 32'd1;
    raddr_1 = 5'd6;
    raddr_2 = 5'd5;
    tick();
    model[6] = 32'd1;
    we = 1'b0;
    #1;
    total++;
    if (rdata_1 !== 32'd1) begin
      bad++;
      $display("FAIL cross_rd1: got %h want %h", rdata_1, 32'd1);
    end
    total++;
    if (rdata_2 !== 32'd10) begin
      bad++;
      $display("FAIL cross_rd2: got %h want %h", rdata_2, 32'd10);
    end
    raddr_1 = 5'd5;
    raddr_2 = 5'd5;
    #1;
    total++;
    if (rdata_1 !== 32'd10) begin
      bad++;
      $display("FAIL same_addr_rd1: got %h want %h", rdata_1, 32'd10);
    end
    total++;
    if (rdata_2 !== 32'd10) begin
      bad++;
      $display("FAIL same_addr_rd2: got %h want %h", rdata_2, 32'd10);
    end
  endtask

  task automatic test_we_gate();
    we      = 1'b0;
    waddr   = 5'd5;
    wdata   = 32'hDEADBEEF;
    raddr_1 = 5'd5;
    tick();
    #1;
    total++;
    if (rdata_1 !== 32'd10) begin
      bad++;
      $display("FAIL we_gate: got %h want %h", rdata_1, 32'd10);
    end
  endtask

  task automatic test_zero_reg();
    we      = 1'b1;
    waddr   = 5'd0;
    wdata   = 32'hFFFFFFFF;
    raddr_1 = 5'd0;
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata_1 !== 32'd0) begin
      bad++;
      $display("FAIL zero_reg: got %h want %h", rdata_1, 32'd0);
    end
  endtask

  task automatic test_async_reset();
    we    = 1'b1;
    waddr = 5'd31;
    wdata = 32'h12345678;
    raddr_1 = 5'd31;
    raddr_2 = 5'd6;
    tick();
    we = 1'b0;
    #1;
    total++;
    if (rdata_1 !== 32'h12345678) begin
      bad++;
      $display("FAIL async_pre_r31: got %h want %h", rdata_1, 32'h12345678);
    end
    // Drop reset between edges; contents must clear without a clock.
    rst_s = 1'b0;
    #1;
    total++;
    if (rdata_1 !== 32'd0) begin
      bad++;
      $display("FAIL async_r31: got %h want %h", rdata_1, 32'd0);
    end
    total++;
    if (rdata_2 !== 32'd0) begin
      bad++;
      $display("FAIL async_r6: got %h want %h", rdata_2, 32'd0);
    end
    raddr_2 = 5'd5;
    #1;
    total++;
    if (rdata_2 !== 32'd0) begin
      bad++;
      $display("FAIL async_r5: got %h want %h", rdata_2, 32'd0);
    end
    model_clear();
    @(negedge clk);
    rst_s = 1'b1;
    we    = 1'b1;
    waddr = 5'd31;
    wdata = 32'hCAFEF00D;
    #1;
    total++;
    if (rdata_1 !== 32'd0) begin
      bad++;
      $display("FAIL async_rewrite_before: got %h want %h", rdata_1, 32'd0);
    end
    tick();
    model[31] = 32'hCAFEF00D;
    we = 1'b0;
    #1;
    total++;
    if (rdata_1 !== 32'hCAFEF00D) begin
      bad++;
      $display("FAIL async_rewrite_after: got %h want %h", rdata_1, 32'hCAFEF00D);
    end
  endtask

  task automatic test_random();
    logic [31:0] exp1;
    logic [31:0] exp2;
    for (int n = 0; n < 400; n++) begin
      rst_s   = ($urandom_range(0, 39) != 0);
      we      = ($urandom_range(0, 3) != 0);
      waddr   = 5'($urandom_range(0, 31));
      wdata   = $urandom;
      raddr_1 = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
      raddr_2 = ($urandom_range(0, 7) == 0) ? raddr_1 : 5'($urandom_range(0, 31));
      if (!rst_s) model_clear();
      #1;
      exp1 = model_read(raddr_1);
      exp2 = model_read(raddr_2);
      total++;
      if (rdata_1 !== exp1) begin
        bad++;
        $display("FAIL rand_rd1 it=%0d addr=%0d: got %h want %h", n, raddr_1, rdata_1, exp1);
      end
      total++;
      if (rdata_2 !== exp2) begin
        bad++;
        $display("FAIL rand_rd2 it=%0d addr=%0d: got %h want %h", n, raddr_2, rdata_2, exp2);
      end
      tick();
      if (rst_s && we && waddr != 5'd0) model[waddr] = wdata;
    end
    rst_s = 1'b1;
    we    = 1'b0;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_clear();
    test_reset();
    test_basic();
    test_cross_port();
    test_we_gate();
    test_zero_reg();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
